score_keeper: RTL and testbench



---
 rtl/score_keeper.sv | 147 ++++++++++++++
 tb/tb_score_keeper.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// ============================================================================
// Module  : score_keeper
// Brief   : Two-stage score accumulator (units of 10 points) with ghost-chain
//           multiplier, once-per-game extra life and optional high score.
//           Optional feature macro: SCORE_HISCORE_EN (hiscore register).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module score_keeper #(
    parameter int SCORE_W           = 18,
    parameter int EXTRA_LIFE_THRESH = 1000,
    parameter int SCORE_MAX         = 262143   // must not exceed 2^SCORE_W-1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               new_game,
    input  logic               pellet_eaten,
    input  logic               power_eaten,
    input  logic               ghost_eaten,
    input  logic               fruit_eaten,
    input  logic [2:0]         fruit_idx,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hiscore,
    output logic [7:0]         ghost_value,
    output logic               extra_life,
    output logic               score_upd
);

    localparam int c_inc_w = 10;
    localparam logic [SCORE_W:0]   c_max_wide = (SCORE_W+1)'(SCORE_MAX);
    localparam logic [SCORE_W-1:0] c_max      = SCORE_W'(SCORE_MAX);
    localparam logic [SCORE_W-1:0] c_thresh   = SCORE_W'(EXTRA_LIFE_THRESH);

    logic [c_inc_w-1:0] r_inc;
    logic [1:0]         r_chain;
    logic               r_life_given;
    logic [SCORE_W-1:0] r_score;
    logic [7:0]         r_ghost_value;
    logic               r_extra_life;
    logic               r_score_upd;

    logic [c_inc_w-1:0] w_inc;
    logic [c_inc_w-1:0] w_fruit_val;
    logic [1:0]         w_chain_base;
    logic [1:0]         w_chain_nxt;
    logic [7:0]         w_ghost_award;
    logic [SCORE_W:0]   w_sum;
    logic [SCORE_W-1:0] w_new_score;
    logic               w_cross;

    always_comb begin
        w_fruit_val = '0;
        if (fruit_eaten) begin
            case (fruit_idx)
                3'd0:    w_fruit_val = 10'd10;
                3'd1:    w_fruit_val = 10'd30;
                3'd2:    w_fruit_val = 10'd50;
                3'd3:    w_fruit_val = 10'd70;
                3'd4:    w_fruit_val = 10'd100;
                3'd5:    w_fruit_val = 10'd200;
                3'd6:    w_fruit_val = 10'd300;
                default: w_fruit_val = 10'd500;
            endcase
        end
    end

    // A power pellet restarts the chain before any same-cycle ghost is valued.
    always_comb begin
        w_chain_base  = power_eaten ? 2'd0 : r_chain;
        w_ghost_award = 8'd20 << w_chain_base;
        w_chain_nxt   = w_chain_base;
        if (ghost_eaten && (w_chain_base != 2'd3)) begin
            w_chain_nxt = w_chain_base + 2'd1;
        end
    end

    always_comb begin
        w_inc = w_fruit_val
              + {{(c_inc_w-1){1'b0}}, pellet_eaten}
              + (power_eaten ? 10'd5 : 10'd0)
              + (ghost_eaten ? {2'b00, w_ghost_award} : 10'd0);
    end

    always_comb begin
        w_sum       = {1'b0, r_score} + {{(SCORE_W+1-c_inc_w){1'b0}}, r_inc};
        w_new_score = (w_sum > c_max_wide) ? c_max : w_sum[SCORE_W-1:0];
        w_cross     = !r_life_given && (r_score < c_thresh) && (w_new_score >= c_thresh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inc         <= '0;
            r_chain       <= 2'd0;
            r_life_given  <= 1'b0;
            r_score       <= '0;
            r_ghost_value <= '0;
            r_extra_life  <= 1'b0;
            r_score_upd   <= 1'b0;
        end else if (new_game) begin
            // Same-cycle events and the in-flight increment are dropped.
            r_inc         <= '0;
            r_chain       <= 2'd0;
            r_life_given  <= 1'b0;
            r_score       <= '0;
            r_ghost_value <= '0;
            r_extra_life  <= 1'b0;
            r_score_upd   <= (r_score != '0);
        end else begin
            r_inc        <= w_inc;
            r_chain      <= w_chain_nxt;
            if (ghost_eaten) begin
                r_ghost_value <= w_ghost_award;
            end
            r_score      <= w_new_score;
            r_score_upd  <= (w_new_score != r_score);
            r_extra_life <= w_cross;
            if (w_cross) begin
                r_life_given <= 1'b1;
            end
        end
    end

`ifdef SCORE_HISCORE_EN
    logic [SCORE_W-1:0] r_hiscore;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hiscore <= '0;
        end else if (!new_game && (w_new_score > r_hiscore)) begin
            r_hiscore <= w_new_score;
        end
    end

    assign hiscore = r_hiscore;
`else
    assign hiscore = '0;
`endif

    assign score       = r_score;
    assign ghost_value = r_ghost_value;
    assign extra_life  = r_extra_life;
    assign score_upd   = r_score_upd;

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ============================================================================
// Module  : tb_score_keeper
// Brief   : Scoreboard bench for score_keeper with a rule-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_keeper;

    localparam int SCORE_W = 18;
    localparam int MAX     = 262143;
    localparam int TH      = 1000;

    typedef struct {
        int score;
        int hi;
        int gv;
        bit el;
        bit upd;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               new_game;
    logic               pellet_eaten;
    logic               power_eaten;
    logic               ghost_eaten;
    logic               fruit_eaten;
    logic [2:0]         fruit_idx;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] hiscore;
    logic [7:0]         ghost_value;
    logic               extra_life;
    logic               score_upd;

    score_keeper dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .new_game     (new_game),
        .pellet_eaten (pellet_eaten),
        .power_eaten  (power_eaten),
        .ghost_eaten  (ghost_eaten),
        .fruit_eaten  (fruit_eaten),
        .fruit_idx    (fruit_idx),
        .score        (score),
        .hiscore      (hiscore),
        .ghost_value  (ghost_value),
        .extra_life   (extra_life),
        .score_upd    (score_upd)
    );

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];

    int fruit_tab[8] = '{10, 30, 50, 70, 100, 200, 300, 500};

    // Reference model: game state in plain integers.
    int m_score, m_hi, m_gv, m_pend, m_ghosts_since_power;
    bit m_life;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("score", int'(score), e.score);
                chk("hiscore", int'(hiscore), e.hi);
                chk("ghost_value", int'(ghost_value), e.gv);
                chk("extra_life", int'(extra_life), int'(e.el));
                chk("score_upd", int'(score_upd), int'(e.upd));
            end
        end
    end

    task automatic model_reset();
        m_score = 0; m_hi = 0; m_gv = 0; m_pend = 0;
        m_ghosts_since_power = 0; m_life = 0;
    endtask

    function automatic int proj();
        return (m_score + m_pend > MAX) ? MAX : m_score + m_pend;
    endfunction

    // Drive one cycle of events and queue the outputs expected after the next edge.
    task automatic step(input bit p, input bit pw, input bit g, input bit f,
                        input int idx, input bit ng);
        exp_t e;
        int ns, v;
        @(negedge clk);
        pellet_eaten = p; power_eaten = pw; ghost_eaten = g;
        fruit_eaten = f; fruit_idx = 3'(idx); new_game = ng;
        e.el = 0;
        if (ng) begin
            e.upd = (m_score != 0);
            m_score = 0; m_pend = 0; m_gv = 0; m_life = 0;
            m_ghosts_since_power = 0;
        end else begin
            ns = (m_score + m_pend > MAX) ? MAX : m_score + m_pend;
            e.upd = (ns != m_score);
            if (!m_life && m_score < TH && ns >= TH) begin
                e.el = 1;
                m_life = 1;
            end
            m_score = ns;
`ifdef SCORE_HISCORE_EN
            if (ns > m_hi) m_hi = ns;
`endif
            v = 0;
            if (p) v += 1;
            if (pw) begin
                v += 5;
                m_ghosts_since_power = 0;
            end
            if (g) begin
                m_gv = 20 * (2 ** ((m_ghosts_since_power > 3) ? 3 : m_ghosts_since_power));
                v += m_gv;
                m_ghosts_since_power++;
            end
            if (f) v += fruit_tab[idx];
            m_pend = v;
        end
        e.score = m_score; e.hi = m_hi; e.gv = m_gv;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        new_game = 0; pellet_eaten = 0; power_eaten = 0;
        ghost_eaten = 0; fruit_eaten = 0; fruit_idx = 3'd0;
        model_reset();
        #13;
        chk("reset score", int'(score), 0);
        chk("reset hiscore", int'(hiscore), 0);
        chk("reset ghost_value", int'(ghost_value), 0);
        chk("reset extra_life", int'(extra_life), 0);
        chk("reset score_upd", int'(score_upd), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three consecutive pellets.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        idle(3);

        // Ghost chain, then power and ghost together.
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, 0, 0);
            idle(1);
        end
        step(0, 1, 1, 0, 0, 0);
        idle(3);

        // All event kinds in one cycle.
        step(0, 0, 0, 0, 0, 1);
        step(1, 1, 1, 1, 7, 0);
        idle(3);

        // Build to 995, then cross the extra-life threshold.
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 4, 0);
        step(0, 0, 0, 1, 3, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 1, 0, 0);
        idle(3);
        for (int i = 0; i < 40; i++)
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 7), 0);
        step(0, 0, 0, 0, 0, 1);
        idle(2);

        // Random play with occasional new_game.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1), ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 7),
                 ($urandom_range(0, 99) == 0));
        idle(2);

        // Saturation: reach SCORE_MAX-3 exactly, then overflow with fruit 4.
        step(0, 0, 0, 0, 0, 1);
        while (proj() + 500 <= MAX - 3) step(0, 0, 0, 1, 7, 0);
        for (int k = 7; k >= 0; k--)
            while (proj() + fruit_tab[k] <= MAX - 3) step(0, 0, 0, 1, k, 0);
        while (proj() + 1 <= MAX - 3) step(1, 0, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 1, 4, 0);
        idle(2);
        step(1, 0, 0, 0, 0, 0);
        idle(3);

        // new_game with a same-cycle pellet at score 465.
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0);
        idle(3);
        step(1, 0, 0, 0, 0, 1);
        idle(3);

        // Asynchronous reset with an increment in flight.
        step(0, 0, 0, 1, 7, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        new_game = 0; pellet_eaten = 0; power_eaten = 0;
        ghost_eaten = 0; fruit_eaten = 0;
        model_reset();
        #1;
        chk("async score", int'(score), 0);
        chk("async hiscore", int'(hiscore), 0);
        chk("async ghost_value", int'(ghost_value), 0);
        chk("async extra_life", int'(extra_life), 0);
        chk("async score_upd", int'(score_upd), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        step(1, 0, 0, 0, 0, 0);
        idle(3);

        @(posedge clk);
        #2;
        chk("queue drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
